// File: rtl/presc_timer_ctrl.sv
// presc_timer_ctrl: one-shot tick timer that sequences an external prescaler.
// Counts prescaler carry-outs down from a loaded value, with pause (hold) and abort.
// Optional feature macro: PTC_AUTO_RELOAD_EN adds the `periodic` input. When it is
// latched high at start, the timer reloads after each expiry and keeps running.
module presc_timer_ctrl #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             start,
   input  logic             abort,
   input  logic             hold,
   input  logic [CNT_W-1:0] load_val,
`ifdef PTC_AUTO_RELOAD_EN
   input  logic             periodic,
`endif
   input  logic             presc_co,
   output logic             presc_ce,
   output logic             presc_clr,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] remaining
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_RUN    = 2'd1,
      ST_PAUSED = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] remaining_q, remaining_d;
   logic             done_q, done_d;
   logic             tick;
   logic             load_zero;
   logic             last_tick;
   logic             start_ok;

`ifdef PTC_AUTO_RELOAD_EN
   // Periodic mode and its reload value are captured when a start is accepted.
   logic             periodic_q, periodic_d;
   logic [CNT_W-1:0] reload_q, reload_d;
`endif

   // Decoded status. The prescaler counts only in RUN and is held cleared in IDLE,
   // so a new run always begins from a fresh prescaler phase.
   assign presc_ce  = (state_q == ST_RUN);
   assign presc_clr = (state_q == ST_IDLE);
   assign busy      = (state_q != ST_IDLE);
   assign done      = done_q;
   assign remaining = remaining_q;

   // The prescaler reports co=1 whenever it is disabled, so only trust co in RUN.
   assign tick      = (state_q == ST_RUN) && presc_co;
   assign load_zero = (load_val == '0);
   assign last_tick = tick && (remaining_q == CNT_W'(1));
   assign start_ok  = start && !abort;

   // State, count and done pulse registers.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state_q     <= ST_IDLE;
         remaining_q <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         done_q      <= done_d;
      end
   end

`ifdef PTC_AUTO_RELOAD_EN
   // Auto-reload configuration registers.
   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         periodic_q <= 1'b0;
         reload_q   <= '0;
      end else begin
         periodic_q <= periodic_d;
         reload_q   <= reload_d;
      end
   end
`endif

   // Next-state logic. In RUN the order is abort, final tick, hold, plain tick.
   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      done_d      = 1'b0;
`ifdef PTC_AUTO_RELOAD_EN
      periodic_d  = periodic_q;
      reload_d    = reload_q;
`endif

      unique case (state_q)
         ST_IDLE: begin
            remaining_d = '0;
            if (start_ok) begin
               if (load_zero) begin
                  // Nothing to wait for: expire immediately, stay idle.
                  done_d = 1'b1;
`ifdef PTC_AUTO_RELOAD_EN
                  periodic_d = 1'b0;
`endif
               end else begin
                  state_d     = ST_RUN;
                  remaining_d = load_val;
`ifdef PTC_AUTO_RELOAD_EN
                  periodic_d  = periodic;
                  reload_d    = load_val;
`endif
               end
            end
         end

         ST_RUN: begin
            if (abort) begin
               // Cancel wins even over a coincident final tick: no done.
               state_d     = ST_IDLE;
               remaining_d = '0;
            end else if (last_tick) begin
               done_d = 1'b1;
`ifdef PTC_AUTO_RELOAD_EN
               if (periodic_q) begin
                  // Stay in RUN; the prescaler keeps free-running into the next period.
                  remaining_d = reload_q;
               end else begin
                  state_d     = ST_IDLE;
                  remaining_d = '0;
               end
`else
               state_d     = ST_IDLE;
               remaining_d = '0;
`endif
            end else begin
               if (hold) begin
                  state_d = ST_PAUSED;
               end
               // A tick landing with hold is still counted; never step below 1 here.
               if (tick && (remaining_q >= CNT_W'(2))) begin
                  remaining_d = remaining_q - CNT_W'(1);
               end
            end
         end

         ST_PAUSED: begin
            // Prescaler is frozen (ce=0, clr=0) so its phase survives the pause.
            if (abort) begin
               state_d     = ST_IDLE;
               remaining_d = '0;
            end else if (!hold) begin
               state_d = ST_RUN;
            end
         end

         default: begin
            state_d     = ST_IDLE;
            remaining_d = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_presc_timer_ctrl.sv
// Directed bench for presc_timer_ctrl with a 2-bit prescaler model (co every 4 enabled cycles).
// Define PTC_AUTO_RELOAD_EN on both files to also exercise periodic mode.
module tb_presc_timer_ctrl;

   localparam int CNT_W = 8;

   logic             clk = 1'b0;
   logic             clr;
   logic             start, abort, hold;
   logic [CNT_W-1:0] load_val;
   logic             presc_co, presc_ce, presc_clr, busy, done;
   logic [CNT_W-1:0] remaining;
`ifdef PTC_AUTO_RELOAD_EN
   logic             periodic;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   // Prescaler model: 2-bit counter, synchronous clear, co=1 when disabled.
   logic [1:0] pcnt;
   always_ff @(posedge clk) begin
      if (presc_clr)     pcnt <= 2'd0;
      else if (presc_ce) pcnt <= pcnt + 2'd1;
   end
   assign presc_co = !presc_ce || (pcnt == 2'd3);

   presc_timer_ctrl #(.CNT_W(CNT_W)) dut (
      .clk       (clk),
      .clr       (clr),
      .start     (start),
      .abort     (abort),
      .hold      (hold),
      .load_val  (load_val),
`ifdef PTC_AUTO_RELOAD_EN
      .periodic  (periodic),
`endif
      .presc_co  (presc_co),
      .presc_ce  (presc_ce),
      .presc_clr (presc_clr),
      .busy      (busy),
      .done      (done),
      .remaining (remaining)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Advance n rising edges, then settle 1 time unit past the last edge.
   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      bit seen;
      clr = 1'b1; start = 1'b0; abort = 1'b0; hold = 1'b0; load_val = '0;
`ifdef PTC_AUTO_RELOAD_EN
      periodic = 1'b0;
`endif
      step(2);
      // 1: reset state
      chk("rst_clr",  presc_clr, 1);
      chk("rst_ce",   presc_ce,  0);
      chk("rst_busy", busy,      0);
      chk("rst_done", done,      0);
      chk("rst_rem",  remaining, 0);
      clr = 1'b0;
      step(2);

      // 2: load 3, no hold -> done after 12th edge
      load_val = 8'd3; start = 1'b1;
      step(1);                 // E0
      start = 1'b0;
      chk("t2_busy", busy, 1);
      chk("t2_ce",   presc_ce, 1);
      chk("t2_rem0", remaining, 3);
      step(4);                 // E4
      chk("t2_rem4", remaining, 2);
      step(4);                 // E8
      chk("t2_rem8", remaining, 1);
      step(3);                 // E11
      chk("t2_done11", done, 0);
      step(1);                 // E12
      chk("t2_done12", done, 1);
      chk("t2_busy12", busy, 0);
      chk("t2_rem12",  remaining, 0);
      chk("t2_clr12",  presc_clr, 1);
      // back-to-back start in the done cycle, load 1 -> done 4 edges later
      load_val = 8'd1; start = 1'b1;
      step(1);
      start = 1'b0;
      chk("b2b_done_drop", done, 0);
      chk("b2b_busy", busy, 1);
      chk("b2b_rem",  remaining, 1);
      step(3);
      chk("b2b_done3", done, 0);
      step(1);
      chk("b2b_done4", done, 1);
      step(1);
      chk("b2b_pulse", done, 0);
      step(2);

      // 3: load 2, hold 5 cycles after RUN cycle 2 -> done at edge 13
      load_val = 8'd2; start = 1'b1;
      step(1);                 // E0
      start = 1'b0;
      step(2);                 // E2
      hold = 1'b1;
      chk("t3_ce_holdrise", presc_ce, 1);
      step(1);                 // E3
      chk("t3_ce_paused", presc_ce, 0);
      chk("t3_clr_paused", presc_clr, 0);
      chk("t3_busy_paused", busy, 1);
      step(4);                 // E7
      hold = 1'b0;
      chk("t3_rem_paused", remaining, 2);
      step(1);                 // E8
      chk("t3_ce_resume", presc_ce, 1);
      chk("t3_done8", done, 0);
      step(1);                 // E9
      chk("t3_rem9", remaining, 1);
      step(3);                 // E12
      chk("t3_done12", done, 0);
      step(1);                 // E13
      chk("t3_done13", done, 1);
      step(2);

      // 4: load 4, abort at RUN cycle 6
      load_val = 8'd4; start = 1'b1;
      step(1);                 // E0
      start = 1'b0;
      step(5);                 // E5
      chk("t4_rem5", remaining, 3);
      abort = 1'b1;
      step(1);                 // E6
      abort = 1'b0;
      chk("t4_busy", busy, 0);
      chk("t4_rem",  remaining, 0);
      chk("t4_clr",  presc_clr, 1);
      seen = 1'b0;
      for (int i = 0; i < 24; i++) begin
         if (done) seen = 1'b1;
         step(1);
      end
      chk("t4_no_done", seen, 0);

      // 5: load 0 -> immediate done, never busy
      load_val = 8'd0; start = 1'b1;
      step(1);
      start = 1'b0;
      chk("t5_done", done, 1);
      chk("t5_busy", busy, 0);
      step(1);
      chk("t5_pulse", done, 0);
      // start while busy is ignored
      load_val = 8'd3; start = 1'b1;
      step(1);
      load_val = 8'd7;
      step(2);
      start = 1'b0;
      chk("t5_ign_rem", remaining, 3);
      chk("t5_ign_busy", busy, 1);
      // async clear mid-run takes effect without a clock edge
      @(negedge clk);
      clr = 1'b1;
      #1;
      chk("aclr_busy", busy, 0);
      chk("aclr_rem",  remaining, 0);
      chk("aclr_clr",  presc_clr, 1);
      step(1);
      clr = 1'b0;
      step(2);

`ifdef PTC_AUTO_RELOAD_EN
      // 6: periodic, load 1 -> done every 4 cycles, abort ends it
      load_val = 8'd1; periodic = 1'b1; start = 1'b1;
      step(1);
      start = 1'b0; periodic = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step(3);
         chk("t6_gap", done, 0);
         step(1);
         chk("t6_done", done, 1);
         chk("t6_busy", busy, 1);
      end
      abort = 1'b1;
      step(1);
      abort = 1'b0;
      chk("t6_abort_busy", busy, 0);
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (done) seen = 1'b1;
         step(1);
      end
      chk("t6_no_done", seen, 0);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
